// File: rtl/fsm_sup_pkg.sv
// Shared codes for the controller supervisor: phase and cause encodings,
// supervisor states and the upstream controller's legal output patterns.
package fsm_sup_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_S1      = 3'd1,
    PH_S2      = 3'd2,
    PH_S3      = 3'd3,
    PH_ERROR   = 3'd4,
    PH_ILLEGAL = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_RUN     = 2'b01,
    CAUSE_PATTERN = 2'b10,
    CAUSE_TRANS   = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    SUP_MON   = 2'd0,
    SUP_ALARM = 2'd1,
    SUP_FLUSH = 2'd2
  } sup_state_e;

  // Patterns are {err, n_o1, o2, o3, o4}
  localparam logic [4:0] PAT_IDLE  = 5'b01000;
  localparam logic [4:0] PAT_S1    = 5'b00100;
  localparam logic [4:0] PAT_S2    = 5'b01110;
  localparam logic [4:0] PAT_S3    = 5'b01001;
  localparam logic [4:0] PAT_ERROR = 5'b11000;

  localparam logic [3:0] RUN_MAX = 4'd15;

endpackage

// File: rtl/fsm_sup_decode.sv
// Combinational pattern decode and legal-transition table for the
// supervised five-state controller.
module fsm_sup_decode
  import fsm_sup_pkg::*;
(
  input  logic [4:0] pat_i,
  input  phase_e     prev_i,
  output phase_e     cur_o,
  output logic       trans_ok_o
);

  // Map the raw output pattern onto a phase code
  always_comb begin
    cur_o = PH_ILLEGAL;
    case (pat_i)
      PAT_IDLE:  cur_o = PH_IDLE;
      PAT_S1:    cur_o = PH_S1;
      PAT_S2:    cur_o = PH_S2;
      PAT_S3:    cur_o = PH_S3;
      PAT_ERROR: cur_o = PH_ERROR;
      default:   cur_o = PH_ILLEGAL;
    endcase
  end

  // Allowed successors of each phase; anything touching ILLEGAL is rejected
  always_comb begin
    trans_ok_o = 1'b0;
    case (prev_i)
      PH_IDLE:  trans_ok_o = (cur_o inside {PH_IDLE, PH_S1, PH_S2, PH_ERROR});
      PH_S1:    trans_ok_o = (cur_o inside {PH_S1, PH_S2, PH_S3, PH_ERROR});
      PH_S2:    trans_ok_o = (cur_o inside {PH_S2, PH_S3, PH_ERROR});
      PH_S3:    trans_ok_o = (cur_o inside {PH_S3, PH_IDLE, PH_ERROR});
      PH_ERROR: trans_ok_o = (cur_o inside {PH_ERROR, PH_IDLE});
      default:  trans_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fsm_supervisor.sv
// Supervisor for an upstream five-state controller: samples its outputs,
// counts error episodes, raises alarms and requests a controller reset.
module fsm_supervisor
  import fsm_sup_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err,
  input  logic             n_o1,
  input  logic             o2,
  input  logic             o3,
  input  logic             o4,
  input  logic             ack,
  input  logic             clr,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] err_episodes,
  output logic             alarm,
  output logic [1:0]       alarm_cause,
  output logic             ctrl_rst_n
);

  localparam logic [3:0]       RUN_LIMIT = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]       pat_d, pat_q;
  phase_e           cur_phase, prev_d, prev_q;
  logic             trans_ok;
  logic             valid_d, valid_q, prev_valid_d, prev_valid_q;
  logic [3:0]       run_d, run_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  sup_state_e       state_d, state_q;
  logic             flush_cnt_d, flush_cnt_q;
  cause_e           cause_d, cause_q;
  logic             alarm_d, alarm_q, ctrl_rst_n_d, ctrl_rst_n_q;
  logic             ill_pat, ill_trans, run_hit, entry;

  assign pat_d = {err, n_o1, o2, o3, o4};

  fsm_sup_decode u_decode (
    .pat_i      (pat_q),
    .prev_i     (prev_q),
    .cur_o      (cur_phase),
    .trans_ok_o (trans_ok)
  );

  // Per-sample bookkeeping; only samples flagged valid feed the checks
  always_comb begin
    run_d        = 4'd0;
    prev_d       = PH_IDLE;
    prev_valid_d = valid_q;
    entry        = 1'b0;
    cnt_d        = cnt_q;
    if (valid_q) begin
      prev_d = cur_phase;
      entry  = (cur_phase == PH_ERROR) && (prev_q != PH_ERROR);
      if (cur_phase == PH_ERROR) begin
        run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1;
      end else begin
        run_d = 4'd0;
      end
    end else begin
      prev_d = PH_IDLE;
      run_d  = 4'd0;
    end
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (entry && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    ill_pat   = valid_q && (cur_phase == PH_ILLEGAL);
    ill_trans = valid_q && prev_valid_q && !trans_ok;
    run_hit   = valid_q && (run_d >= RUN_LIMIT);
  end

  // Supervisor next state, alarm cause and registered output values
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    cause_d     = cause_q;
    case (state_q)
      SUP_MON: begin
        if (ill_pat) begin
          state_d = SUP_ALARM;
          cause_d = CAUSE_PATTERN;
        end else if (ill_trans) begin
          state_d = SUP_ALARM;
          cause_d = CAUSE_TRANS;
        end else if (run_hit) begin
          state_d = SUP_ALARM;
          cause_d = CAUSE_RUN;
        end else begin
          state_d = SUP_MON;
        end
      end
      SUP_ALARM: begin
        if (ack) begin
          state_d     = SUP_FLUSH;
          flush_cnt_d = 1'b0;
          cause_d     = CAUSE_NONE;
        end else begin
          state_d = SUP_ALARM;
        end
      end
      SUP_FLUSH: begin
        cause_d = CAUSE_NONE;
        if (flush_cnt_q) begin
          state_d     = SUP_MON;
          flush_cnt_d = 1'b0;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d     = SUP_MON;
        flush_cnt_d = 1'b0;
        cause_d     = CAUSE_NONE;
      end
    endcase
    // The sample taken on the edge leaving FLUSH is still discarded
    valid_d      = (state_q != SUP_FLUSH) && (state_d != SUP_FLUSH);
    alarm_d      = (state_d == SUP_ALARM);
    ctrl_rst_n_d = (state_d != SUP_FLUSH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q        <= PAT_IDLE;
      prev_q       <= PH_IDLE;
      valid_q      <= 1'b0;
      prev_valid_q <= 1'b0;
      run_q        <= 4'd0;
      cnt_q        <= {CNT_W{1'b0}};
      state_q      <= SUP_MON;
      flush_cnt_q  <= 1'b0;
      cause_q      <= CAUSE_NONE;
      alarm_q      <= 1'b0;
      ctrl_rst_n_q <= 1'b1;
    end else begin
      pat_q        <= pat_d;
      prev_q       <= prev_d;
      valid_q      <= valid_d;
      prev_valid_q <= prev_valid_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      cause_q      <= cause_d;
      alarm_q      <= alarm_d;
      ctrl_rst_n_q <= ctrl_rst_n_d;
    end
  end

  assign phase        = cur_phase;
  assign phase_valid  = valid_q;
  assign err_episodes = cnt_q;
  assign alarm        = alarm_q;
  assign alarm_cause  = cause_q;
  assign ctrl_rst_n   = ctrl_rst_n_q;

endmodule

// File: tb/tb_fsm_supervisor.sv
// Directed bench for fsm_supervisor: a history-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_fsm_supervisor;

  localparam int ERR_LIMIT = 4;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = 255;

  localparam logic [4:0] P_IDLE = 5'b01000;
  localparam logic [4:0] P_S1   = 5'b00100;
  localparam logic [4:0] P_S2   = 5'b01110;
  localparam logic [4:0] P_S3   = 5'b01001;
  localparam logic [4:0] P_ERR  = 5'b11000;
  localparam logic [4:0] P_BAD  = 5'b10101;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       pat = P_IDLE;
  logic             ack = 1'b0;
  logic             clr = 1'b0;
  logic             err, n_o1, o2, o3, o4;
  logic [2:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] err_episodes;
  logic             alarm;
  logic [1:0]       alarm_cause;
  logic             ctrl_rst_n;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  assign {err, n_o1, o2, o3, o4} = pat;

  always #5 clk = ~clk;

  fsm_supervisor #(.ERR_LIMIT(ERR_LIMIT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .err          (err),
    .n_o1         (n_o1),
    .o2           (o2),
    .o3           (o3),
    .o4           (o4),
    .ack          (ack),
    .clr          (clr),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .err_episodes (err_episodes),
    .alarm        (alarm),
    .alarm_cause  (alarm_cause),
    .ctrl_rst_n   (ctrl_rst_n)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [4:0] p);
    case (p)
      5'b01000: return 0;
      5'b00100: return 1;
      5'b01110: return 2;
      5'b01001: return 3;
      5'b11000: return 4;
      default:  return 7;
    endcase
  endfunction

  function automatic bit legal(input int a, input int b);
    logic [7:0] m;
    case (a)
      0:       m = 8'b0001_0111;
      1:       m = 8'b0001_1110;
      2:       m = 8'b0001_1100;
      3:       m = 8'b0001_1001;
      4:       m = 8'b0001_0001;
      default: m = 8'b0000_0000;
    endcase
    return m[b];
  endfunction

  // Reference model: what must be visible after each edge
  int m_phase = 0;
  bit m_valid = 0;
  int m_eps = 0;
  bit m_alarm = 0;
  int m_cause = 0;
  bit m_rstn = 1;
  int mode = 0;          // 0 watching, 1 alarmed, 2 flushing
  int flush_left = 0;
  int hist[$];           // valid samples since last reset/flush

  always @(posedge clk or negedge rst) begin
    int cur, prevp, run, fault;
    bit have_prev, entered, was_flush;
    if (!rst) begin
      m_phase = 0; m_valid = 0; m_eps = 0; m_alarm = 0; m_cause = 0; m_rstn = 1;
      mode = 0; flush_left = 0; hist.delete();
    end else begin
      cur = m_phase; fault = 0; entered = 0;
      if (m_valid) begin
        have_prev = hist.size() > 0;
        prevp = have_prev ? hist[hist.size()-1] : 0;
        entered = (cur == 4) && !(have_prev && prevp == 4);
        hist.push_back(cur);
        if (hist.size() > 20) void'(hist.pop_front());
        run = 0;
        for (int k = hist.size() - 1; k >= 0 && hist[k] == 4; k--) run++;
        if (run > 15) run = 15;
        if (cur == 7) fault = 2;
        else if (have_prev && !legal(prevp, cur)) fault = 3;
        else if (run >= ERR_LIMIT) fault = 1;
      end
      if (clr) m_eps = 0;
      else if (entered && m_eps < CNT_MAX) m_eps++;
      was_flush = (mode == 2);
      case (mode)
        0: if (fault != 0) begin mode = 1; m_cause = fault; end
        1: if (ack) begin mode = 2; flush_left = 2; m_cause = 0; hist.delete(); end
        default: begin flush_left--; if (flush_left == 0) mode = 0; end
      endcase
      m_valid = !was_flush && (mode != 2);
      m_phase = decode(pat);
      m_alarm = (mode == 1);
      m_rstn  = (mode != 2);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("phase", phase, m_phase);
      check("phase_valid", phase_valid, m_valid);
      check("err_episodes", err_episodes, m_eps);
      check("alarm", alarm, m_alarm);
      check("alarm_cause", alarm_cause, m_cause);
      check("ctrl_rst_n", ctrl_rst_n, m_rstn);
    end
  end

  task automatic step(input logic [4:0] p, input logic a = 1'b0, input logic c = 1'b0);
    pat = p; ack = a; clr = c;
    @(negedge clk);
  endtask

  task automatic flush_seq(input logic [4:0] pd, input logic [4:0] pf);
    step(pd, 1'b1, 1'b0);
    check("fl1_rstn", ctrl_rst_n, 0); check("fl1_alarm", alarm, 0);
    check("fl1_cause", alarm_cause, 0); check("fl1_valid", phase_valid, 0);
    step(pd, 1'b1, 1'b0);
    check("fl2_rstn", ctrl_rst_n, 0); check("fl2_valid", phase_valid, 0);
    step(pd);
    check("fl3_rstn", ctrl_rst_n, 1); check("fl3_valid", phase_valid, 0);
    check("fl3_alarm", alarm, 0);
    step(pf);
    check("fl4_valid", phase_valid, 1); check("fl4_alarm", alarm, 0);
    step(pf);
    check("fl5_skip_alarm", alarm, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_phase", phase, 0); check("rst_valid", phase_valid, 0);
    check("rst_eps", err_episodes, 0); check("rst_alarm", alarm, 0);
    check("rst_cause", alarm_cause, 0); check("rst_ctrl", ctrl_rst_n, 1);
    rst = 1'b1;

    // Normal cycle through the legal phases
    step(P_IDLE); check("seq_p0", phase, 0); check("seq_valid", phase_valid, 1);
    step(P_S1);   check("seq_p1", phase, 1);
    step(P_S2);   check("seq_p2", phase, 2);
    step(P_S3);   check("seq_p3", phase, 3);
    step(P_IDLE); check("seq_p0b", phase, 0);
    check("seq_alarm", alarm, 0); check("seq_eps", err_episodes, 0);

    // Error run reaching the limit
    repeat (4) step(P_ERR);
    check("run_phase", phase, 4); check("run_alarm_early", alarm, 0);
    check("run_eps", err_episodes, 1);
    step(P_ERR);
    check("run_alarm", alarm, 1); check("run_cause", alarm_cause, 1);
    flush_seq(P_BAD, P_S3);

    // Illegal pattern, also an illegal transition
    step(P_IDLE);
    step(P_BAD); check("pat_phase", phase, 7); check("pat_alarm_early", alarm, 0);
    step(P_IDLE); check("pat_alarm", alarm, 1); check("pat_cause", alarm_cause, 2);
    flush_seq(P_BAD, P_S3);

    // ack in MON is ignored
    step(P_IDLE, 1'b1, 1'b0);
    check("ack_mon_alarm", alarm, 0); check("ack_mon_ctrl", ctrl_rst_n, 1);

    // Illegal transition S2 -> S1
    step(P_S2);
    step(P_S1); check("tr_phase", phase, 1); check("tr_alarm_early", alarm, 0);
    step(P_S1); check("tr_alarm", alarm, 1); check("tr_cause", alarm_cause, 3);
    flush_seq(P_BAD, P_S3);

    // Episode counter: clear wins, then saturation
    step(P_IDLE, 1'b0, 1'b1); check("clr_eps", err_episodes, 0);
    for (int i = 1; i <= 260; i++) begin
      step(P_ERR);
      step(P_IDLE, 1'b0, (i == 100));
      if (i == 99)  check("eps_99", err_episodes, 99);
      if (i == 100) check("eps_clr_win", err_episodes, 0);
    end
    check("eps_160", err_episodes, 160);
    for (int i = 0; i < 100; i++) begin
      step(P_ERR);
      step(P_IDLE);
    end
    check("eps_sat", err_episodes, 255);

    // Reset in the middle of FLUSH
    step(P_BAD);
    step(P_IDLE); check("rf_alarm", alarm, 1);
    step(P_S2, 1'b1, 1'b0); check("rf_ctrl_low", ctrl_rst_n, 0); check("rf_phase", phase, 2);
    #2 rst = 1'b0;
    #1;
    check("rf_phase0", phase, 0); check("rf_valid0", phase_valid, 0);
    check("rf_eps0", err_episodes, 0); check("rf_alarm0", alarm, 0);
    check("rf_cause0", alarm_cause, 0); check("rf_ctrl1", ctrl_rst_n, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(P_S3); check("rf_first_phase", phase, 3); check("rf_first_valid", phase_valid, 1);
    step(P_S3); check("rf_skip_alarm", alarm, 0);
    step(P_IDLE);
    step(P_IDLE); check("rf_end_alarm", alarm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_supervisor.md
FSM_SUPERVISOR -- requirements
Module: fsm_supervisor

Interface
REQ-001 Parameter ERR_LIMIT, default 4: consecutive ERROR-phase samples that raise a run alarm; legal range 2..15.
REQ-002 Parameter CNT_W, default 8: width of the error-episode counter.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 err, n_o1, o2, o3, o4  in  1 each  outputs of the upstream five-state controller, synchronous to clk.
REQ-006 ack  in  1  alarm acknowledge, level, sampled each cycle.
REQ-007 clr  in  1  synchronous clear of the episode counter.
REQ-008 phase  out  3  decoded controller phase: IDLE=0, S1=1, S2=2, S3=3, ERROR=4, ILLEGAL=7.
REQ-009 phase_valid  out  1  high when phase holds a sample taken since the last reset or flush.
REQ-010 err_episodes  out  CNT_W  saturating count of entries into ERROR.
REQ-011 alarm  out  1  supervisor alarm.
REQ-012 alarm_cause  out  2  00 none, 01 error run, 10 illegal pattern, 11 illegal transition.
REQ-013 ctrl_rst_n  out  1  active-low reset request to the upstream controller.

Function
REQ-014 The five inputs shall be registered once; phase shall be decoded from the registered value, so phase reflects inputs presented one edge earlier.
REQ-015 Legal patterns {err,n_o1,o2,o3,o4}: IDLE 01000, S1 00100, S2 01110, S3 01001, ERROR 11000; any other pattern shall decode to ILLEGAL.
REQ-016 Legal transitions prev->cur: IDLE->{IDLE,S1,S2,ERROR}; S1->{S1,S2,S3,ERROR}; S2->{S2,S3,ERROR}; S3->{S3,IDLE,ERROR}; ERROR->{ERROR,IDLE}; all others are illegal.
REQ-017 The transition check shall be skipped for the first valid sample after reset or flush.
REQ-018 A run counter shall increment on each consecutive ERROR sample, clear on any non-ERROR sample, and saturate at 15.
REQ-019 err_episodes shall increment on prev!=ERROR and cur==ERROR, saturate at all-ones, and clear on clr; clr wins over a simultaneous increment.
REQ-020 Supervisor FSM states: MON, ALARM, FLUSH.
REQ-021 MON: fault detection active; on fault, next state ALARM, latch alarm_cause.
REQ-022 Fault priority: illegal pattern > illegal transition > run counter reaching ERR_LIMIT.
REQ-023 alarm shall be high exactly while in ALARM, asserting on the edge after the faulting sample is registered (two edges after input presentation).
REQ-024 ALARM: new faults ignored and alarm_cause held; ack=1 moves to FLUSH.
REQ-025 FLUSH: ctrl_rst_n=0 for exactly 2 cycles, phase_valid=0, run counter and previous-phase register cleared, alarm_cause cleared; then MON.
REQ-026 Faults present during FLUSH and on the first cycle back in MON shall not raise an alarm; the transition check remains suppressed per REQ-017.
REQ-027 ack in MON or FLUSH shall have no effect.
REQ-028 err_episodes shall keep counting in all supervisor states and shall not be cleared by FLUSH.

Reset
REQ-029 While rst=0: state MON, phase=IDLE, phase_valid=0, run counter 0, err_episodes 0, alarm 0, alarm_cause 00, ctrl_rst_n 1.
REQ-030 Reset asserted mid-ALARM or mid-FLUSH shall abandon the operation immediately; the first sample after release is treated per REQ-017.

Structure
REQ-031 Package fsm_sup_pkg shall hold phase codes, cause codes, supervisor state encoding and the legal-pattern constants.
REQ-032 Pattern decode and legal-transition table shall live in sub-module fsm_sup_decode (combinational); counters and supervisor FSM in the top.

Verification
REQ-033 Sequence IDLE,S1,S2,S3,IDLE patterns -> phase 0,1,2,3,0 one cycle late; alarm stays 0; err_episodes 0.
REQ-034 ERROR pattern held 4 cycles, ERR_LIMIT=4 -> alarm=1 with cause 01 two edges after the 4th sample; err_episodes=1.
REQ-035 Pattern 10101 for one cycle -> phase=7, alarm cause 10; simultaneous illegal transition does not change the cause.
REQ-036 S2 followed by S1 -> alarm cause 11; ack=1 -> ctrl_rst_n low exactly 2 cycles, then MON with phase_valid=0 for the first sample.
REQ-037 260 ERROR entries with clr pulsed on the same cycle as the 100th entry -> counter reads 0 after that entry and ends at 160; with no clr the counter saturates at 255.
REQ-038 rst asserted during FLUSH -> all outputs take REQ-029 values immediately, ctrl_rst_n returns to 1.
